// File: rtl/can_tx_mbox_sched_pkg.sv
// Shared constants for the CAN TX mailbox scheduler: FSM encoding, retry counter
// type and mailbox index sizing.
package can_tx_mbox_sched_pkg;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_SELECT = 2'd1;
  localparam logic [STATE_W-1:0] S_REQ    = 2'd2;
  localparam logic [STATE_W-1:0] S_WAIT   = 2'd3;

  localparam int unsigned RETRY_W = 8;
  typedef logic [RETRY_W-1:0] retry_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturating increment so a long error burst never wraps back to zero
  function automatic retry_t retry_inc(input retry_t r);
    return (r == '1) ? r : r + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/can_tx_mbox_sched_if.sv
// Scheduler <-> CAN TX bit engine handshake. master = scheduler, slave = engine.
interface can_tx_mbox_sched_if #(
  parameter int unsigned ID_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 64
);

  logic [ID_WIDTH-1:0]   tx_id;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_req;
  logic                  tx_cancel;
  logic                  tx_done;
  logic                  arb_lost;
  logic                  active_err;
  logic                  tx_empty;

  modport master (
    output tx_id, tx_data, tx_req, tx_cancel,
    input  tx_done, arb_lost, active_err, tx_empty
  );

  modport slave (
    input  tx_id, tx_data, tx_req, tx_cancel,
    output tx_done, arb_lost, active_err, tx_empty
  );

endinterface

// File: rtl/can_tx_mbox_sched_prio_select.sv
// Combinational arbiter: busy mailbox with the lowest ID wins, ties to the
// lowest index.
module can_tx_mbox_sched_prio_select
  import can_tx_mbox_sched_pkg::*;
#(
  parameter int unsigned NUM_MBOX = 4,
  parameter int unsigned ID_WIDTH = 32
) (
  input  logic [NUM_MBOX-1:0]            busy,
  input  logic [ID_WIDTH-1:0]            id [NUM_MBOX],
  output logic [idx_width(NUM_MBOX)-1:0] win_idx,
  output logic                           win_valid
);

  localparam int unsigned IDX_W = idx_width(NUM_MBOX);

  logic [ID_WIDTH-1:0] best_id;

  // Strict less-than keeps the earlier (lower) index on equal IDs
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_id   = '0;
    for (int i = 0; i < NUM_MBOX; i++) begin
      if (busy[i] && (!win_valid || (id[i] < best_id))) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        best_id   = id[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_mbox_sched.sv
// CAN transmit mailbox scheduler: holds pending frames, offers the highest
// priority one to the TX engine and handles retry, cancel and watchdog abort.
module can_tx_mbox_sched
  import can_tx_mbox_sched_pkg::*;
#(
  parameter int unsigned NUM_MBOX    = 4,
  parameter int unsigned ID_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned RETRY_LIMIT = 8,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                            clk_can,
  input  logic                            rst,
  input  logic                            mb_wr_en,
  input  logic [idx_width(NUM_MBOX)-1:0]  mb_wr_idx,
  input  logic [ID_WIDTH-1:0]             mb_wr_id,
  input  logic [DATA_WIDTH-1:0]           mb_wr_data,
  input  logic [NUM_MBOX-1:0]             mb_cancel,
  output logic [NUM_MBOX-1:0]             mb_busy,
  output logic [NUM_MBOX-1:0]             mb_done,
  output logic [NUM_MBOX-1:0]             mb_abort,
  output logic                            mb_wr_rej,
  can_tx_mbox_sched_if.master             eng
);

  localparam int unsigned IDX_W  = idx_width(NUM_MBOX);
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [NUM_MBOX-1:0]   busy_q, busy_d;
  logic [IDX_W-1:0]      act_q, act_d;
  logic                  cflag_q, cflag_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  retry_t                retry_q [NUM_MBOX];
  retry_t                retry_d [NUM_MBOX];
  logic [NUM_MBOX-1:0]   done_q, done_d;
  logic [NUM_MBOX-1:0]   abort_q, abort_d;
  logic                  rej_q, rej_d;
  logic                  tx_req_q, tx_cancel_q;
  logic [ID_WIDTH-1:0]   tx_id_q, tx_id_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  wdog_fire;

  logic [ID_WIDTH-1:0]   id_q   [NUM_MBOX];
  logic [DATA_WIDTH-1:0] data_q [NUM_MBOX];

  logic [IDX_W-1:0]      win_idx;
  logic                  win_valid;
  logic [IDX_W-1:0]      act_cur;
  logic                  act_live;
  logic                  wr_hit;
  logic                  wr_accept;
  retry_t                retry_nxt;

  can_tx_mbox_sched_prio_select #(
    .NUM_MBOX (NUM_MBOX),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio (
    .busy      (busy_q),
    .id        (id_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // The mailbox currently owned by the FSM is handled there, not by the plain cancel path
  assign act_cur   = (state_q == S_SELECT) ? win_idx : act_q;
  assign act_live  = ((state_q == S_SELECT) && win_valid) || (state_q == S_REQ) || (state_q == S_WAIT);
  assign wr_hit    = mb_wr_en && (32'(mb_wr_idx) < NUM_MBOX);
  assign wr_accept = wr_hit && !busy_q[mb_wr_idx];
  assign retry_nxt = retry_inc(retry_q[act_q]);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    act_d     = act_q;
    cflag_d   = cflag_q;
    wdog_d    = wdog_q;
    retry_d   = retry_q;
    done_d    = '0;
    abort_d   = '0;
    rej_d     = 1'b0;
    tx_id_d   = tx_id_q;
    tx_data_d = tx_data_q;
    wdog_fire = 1'b0;

    for (int i = 0; i < NUM_MBOX; i++) begin
      if (mb_cancel[i] && busy_q[i] && !(act_live && (act_cur == IDX_W'(i)))) begin
        busy_d[i]  = 1'b0;
        abort_d[i] = 1'b1;
      end
    end

    if (wr_hit) begin
      if (busy_q[mb_wr_idx]) begin
        rej_d = 1'b1;
      end else begin
        busy_d[mb_wr_idx]  = 1'b1;
        retry_d[mb_wr_idx] = '0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if ((|busy_q) && eng.tx_empty) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (!win_valid) begin
          state_d = S_IDLE;
        end else if (mb_cancel[win_idx]) begin
          busy_d[win_idx]  = 1'b0;
          abort_d[win_idx] = 1'b1;
          state_d          = S_IDLE;
        end else begin
          act_d     = win_idx;
          tx_id_d   = id_q[win_idx];
          tx_data_d = data_q[win_idx];
          cflag_d   = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        wdog_d  = '0;
        state_d = S_WAIT;
        if (mb_cancel[act_q]) cflag_d = 1'b1;
      end
      S_WAIT: begin
        if (eng.tx_done) begin
          busy_d[act_q]  = 1'b0;
          done_d[act_q]  = 1'b1;
          retry_d[act_q] = '0;
          cflag_d        = 1'b0;
          state_d        = S_IDLE;
        end else if (eng.arb_lost || eng.active_err) begin
          if (cflag_q || mb_cancel[act_q]) begin
            busy_d[act_q]  = 1'b0;
            abort_d[act_q] = 1'b1;
          end else if (!eng.arb_lost) begin
            retry_d[act_q] = retry_nxt;
            if (retry_nxt == RETRY_W'(RETRY_LIMIT)) begin
              busy_d[act_q]  = 1'b0;
              abort_d[act_q] = 1'b1;
            end
          end
          cflag_d = 1'b0;
          state_d = S_IDLE;
        end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          wdog_fire      = 1'b1;
          busy_d[act_q]  = 1'b0;
          abort_d[act_q] = 1'b1;
          cflag_d        = 1'b0;
          state_d        = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
          if (mb_cancel[act_q]) cflag_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_can) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= '0;
      act_q       <= '0;
      cflag_q     <= 1'b0;
      wdog_q      <= '0;
      done_q      <= '0;
      abort_q     <= '0;
      rej_q       <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_cancel_q <= 1'b0;
      tx_id_q     <= '0;
      tx_data_q   <= '0;
      for (int i = 0; i < NUM_MBOX; i++) retry_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      act_q       <= act_d;
      cflag_q     <= cflag_d;
      wdog_q      <= wdog_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      rej_q       <= rej_d;
      tx_req_q    <= (state_d == S_REQ);
      tx_cancel_q <= cflag_d | wdog_fire;
      tx_id_q     <= tx_id_d;
      tx_data_q   <= tx_data_d;
      retry_q     <= retry_d;
    end
  end

  // Frame storage needs no reset: busy gates every use of it
  always_ff @(posedge clk_can) begin
    if (wr_accept) begin
      id_q[mb_wr_idx]   <= mb_wr_id;
      data_q[mb_wr_idx] <= mb_wr_data;
    end
  end

  assign mb_busy       = busy_q;
  assign mb_done       = done_q;
  assign mb_abort      = abort_q;
  assign mb_wr_rej     = rej_q;
  assign eng.tx_id     = tx_id_q;
  assign eng.tx_data   = tx_data_q;
  assign eng.tx_req    = tx_req_q;
  assign eng.tx_cancel = tx_cancel_q;

endmodule

// File: tb/tb_can_tx_mbox_sched.sv
// Self-checking bench for can_tx_mbox_sched; the bench plays the TX engine and
// holds expected frames in a scoreboard queue.
module tb_can_tx_mbox_sched;

  localparam int unsigned NUM_MBOX    = 4;
  localparam int unsigned ID_W        = 32;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned RETRY_LIMIT = 3;
  localparam int unsigned WDOG_CYCLES = 16;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } frame_t;

  logic              clk_can = 1'b0;
  logic              rst;
  logic              mb_wr_en;
  logic [1:0]        mb_wr_idx;
  logic [ID_W-1:0]   mb_wr_id;
  logic [DATA_W-1:0] mb_wr_data;
  logic [3:0]        mb_cancel;
  logic [3:0]        mb_busy, mb_done, mb_abort;
  logic              mb_wr_rej;

  int     n_cmp = 0;
  int     n_err = 0;
  frame_t exp_q[$];
  frame_t got, exp_f;
  bit     seen;
  int     w;

  always #5 clk_can = ~clk_can;

  can_tx_mbox_sched_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W)) eng_if ();

  can_tx_mbox_sched #(
    .NUM_MBOX    (NUM_MBOX),
    .ID_WIDTH    (ID_W),
    .DATA_WIDTH  (DATA_W),
    .RETRY_LIMIT (RETRY_LIMIT),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .clk_can    (clk_can),
    .rst        (rst),
    .mb_wr_en   (mb_wr_en),
    .mb_wr_idx  (mb_wr_idx),
    .mb_wr_id   (mb_wr_id),
    .mb_wr_data (mb_wr_data),
    .mb_cancel  (mb_cancel),
    .mb_busy    (mb_busy),
    .mb_done    (mb_done),
    .mb_abort   (mb_abort),
    .mb_wr_rej  (mb_wr_rej),
    .eng        (eng_if)
  );

  function automatic logic [DATA_W-1:0] mkdata(input int idx, input logic [ID_W-1:0] id);
    return {32'hDA7A_0000 | 32'(idx), id ^ 32'h5A5A_5A5A};
  endfunction

  task automatic tick();
    @(posedge clk_can);
    #1;
  endtask

  task automatic write_mb(input int idx, input logic [ID_W-1:0] id);
    mb_wr_en   = 1'b1;
    mb_wr_idx  = 2'(idx);
    mb_wr_id   = id;
    mb_wr_data = mkdata(idx, id);
    tick();
    mb_wr_en   = 1'b0;
  endtask

  // kind: 0 = tx_done, 1 = arb_lost, 2 = active_err
  task automatic pulse_resp(input int kind);
    case (kind)
      0:       eng_if.tx_done    = 1'b1;
      1:       eng_if.arb_lost   = 1'b1;
      default: eng_if.active_err = 1'b1;
    endcase
    tick();
    eng_if.tx_done    = 1'b0;
    eng_if.arb_lost   = 1'b0;
    eng_if.active_err = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit s, output frame_t f, output int waited);
    s = 1'b0;
    f = '0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      if (eng_if.tx_req) begin
        s = 1'b1;
        f = {eng_if.tx_id, eng_if.tx_data};
        return;
      end
      tick();
      waited++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (mb_busy !== 4'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0000", mb_busy); end
    n_cmp++;
    if ({mb_done, mb_abort, mb_wr_rej} !== 9'b0) begin
      n_err++; $display("FAIL reset_pulses: done=%b abort=%b rej=%b want all 0", mb_done, mb_abort, mb_wr_rej);
    end
    n_cmp++;
    if ({eng_if.tx_req, eng_if.tx_cancel, eng_if.tx_id} !== 34'b0) begin
      n_err++; $display("FAIL reset_engine: req=%b cancel=%b id=%h want 0", eng_if.tx_req, eng_if.tx_cancel, eng_if.tx_id);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    write_mb(2, 32'h120);
    write_mb(0, 32'h300);
    exp_q.push_back({32'h120, mkdata(2, 32'h120)});
    exp_q.push_back({32'h300, mkdata(0, 32'h300)});
    wait_req(64, seen, got, w);
    n_cmp++;
    if (!seen || w != 1) begin n_err++; $display("FAIL prio_latency: seen=%0b waited=%0d want 1", seen, w); end
    exp_f = exp_q.pop_front();
    n_cmp++;
    if (!seen || got !== exp_f) begin n_err++; $display("FAIL prio_first: got %h want %h", got, exp_f); end
    tick(); pulse_resp(0);
    n_cmp++;
    if ({mb_done, mb_busy} !== 8'b0100_0001) begin
      n_err++; $display("FAIL prio_done2: done=%b busy=%b want 0100/0001", mb_done, mb_busy);
    end
    wait_req(64, seen, got, w);
    exp_f = exp_q.pop_front();
    n_cmp++;
    if (!seen || got !== exp_f) begin n_err++; $display("FAIL prio_second: got %h want %h", got, exp_f); end
    tick(); pulse_resp(0);
    n_cmp++;
    if ({mb_done, mb_busy} !== 8'b0001_0000) begin
      n_err++; $display("FAIL prio_done0: done=%b busy=%b want 0001/0000", mb_done, mb_busy);
    end
  endtask

  task automatic test_tie();
    write_mb(3, 32'h77);
    write_mb(1, 32'h77);
    exp_q.push_back({32'h77, mkdata(1, 32'h77)});
    exp_q.push_back({32'h77, mkdata(3, 32'h77)});
    for (int k = 0; k < 2; k++) begin
      wait_req(64, seen, got, w);
      exp_f = exp_q.pop_front();
      n_cmp++;
      if (!seen || got !== exp_f) begin n_err++; $display("FAIL tie_req%0d: got %h want %h", k, got, exp_f); end
      tick(); pulse_resp(0);
      n_cmp++;
      if (mb_done !== ((k == 0) ? 4'b0010 : 4'b1000)) begin
        n_err++; $display("FAIL tie_done%0d: got %b want %b", k, mb_done, (k == 0) ? 4'b0010 : 4'b1000);
      end
    end
  endtask

  task automatic test_arb_lost();
    write_mb(1, 32'h200);
    exp_q.push_back({32'h200, mkdata(1, 32'h200)});
    wait_req(64, seen, got, w);
    exp_f = exp_q.pop_front();
    n_cmp++;
    if (!seen || got !== exp_f) begin n_err++; $display("FAIL arb_first: got %h want %h", got, exp_f); end
    tick();
    write_mb(3, 32'h050);
    pulse_resp(1);
    n_cmp++;
    if ({mb_busy, mb_done, mb_abort} !== 12'b1010_0000_0000) begin
      n_err++; $display("FAIL arb_requeue: busy=%b done=%b abort=%b want 1010/0000/0000", mb_busy, mb_done, mb_abort);
    end
    exp_q.push_back({32'h050, mkdata(3, 32'h050)});
    exp_q.push_back({32'h200, mkdata(1, 32'h200)});
    for (int k = 0; k < 2; k++) begin
      wait_req(64, seen, got, w);
      exp_f = exp_q.pop_front();
      n_cmp++;
      if (!seen || got !== exp_f) begin n_err++; $display("FAIL arb_req%0d: got %h want %h", k, got, exp_f); end
      tick(); pulse_resp(0);
    end
    n_cmp++;
    if ({mb_done, mb_busy} !== 8'b0010_0000) begin
      n_err++; $display("FAIL arb_final: done=%b busy=%b want 0010/0000", mb_done, mb_busy);
    end
  endtask

  task automatic test_retry();
    write_mb(0, 32'h10);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({32'h10, mkdata(0, 32'h10)});
      wait_req(64, seen, got, w);
      exp_f = exp_q.pop_front();
      n_cmp++;
      if (!seen || got !== exp_f) begin n_err++; $display("FAIL retry_req%0d: got %h want %h", k, got, exp_f); end
      tick(); pulse_resp(2);
      n_cmp++;
      if ({mb_abort, mb_busy} !== ((k < 2) ? 8'b0000_0001 : 8'b0001_0000)) begin
        n_err++; $display("FAIL retry_state%0d: abort=%b busy=%b want %b", k, mb_abort, mb_busy,
                          (k < 2) ? 8'b0000_0001 : 8'b0001_0000);
      end
    end
    wait_req(12, seen, got, w);
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL retry_no_more: got tx_req id=%h want none", got.id); end
  endtask

  task automatic test_cancel();
    for (int k = 0; k < 2; k++) begin
      write_mb(1, 32'hAA + 32'(k));
      exp_q.push_back({32'hAA + 32'(k), mkdata(1, 32'hAA + 32'(k))});
      wait_req(64, seen, got, w);
      exp_f = exp_q.pop_front();
      n_cmp++;
      if (!seen || got !== exp_f) begin n_err++; $display("FAIL cancel_req%0d: got %h want %h", k, got, exp_f); end
      tick();
      mb_cancel = 4'b0010;
      tick();
      mb_cancel = 4'b0000;
      n_cmp++;
      if (eng_if.tx_cancel !== 1'b1) begin n_err++; $display("FAIL cancel_level%0d: got %b want 1", k, eng_if.tx_cancel); end
      pulse_resp((k == 0) ? 1 : 0);
      n_cmp++;
      if ({mb_done, mb_abort, mb_busy, eng_if.tx_cancel} !== ((k == 0) ? 13'b0000_0010_0000_0 : 13'b0010_0000_0000_0)) begin
        n_err++; $display("FAIL cancel_resolve%0d: done=%b abort=%b busy=%b txc=%b", k, mb_done, mb_abort, mb_busy, eng_if.tx_cancel);
      end
      wait_req(12, seen, got, w);
      n_cmp++;
      if (seen) begin n_err++; $display("FAIL cancel_no_req%0d: got tx_req id=%h want none", k, got.id); end
    end
    write_mb(3, 32'h400);
    write_mb(2, 32'h100);
    exp_q.push_back({32'h100, mkdata(2, 32'h100)});
    wait_req(64, seen, got, w);
    exp_f = exp_q.pop_front();
    n_cmp++;
    if (!seen || got !== exp_f) begin n_err++; $display("FAIL cancel_other_req: got %h want %h", got, exp_f); end
    tick();
    mb_cancel = 4'b1000;
    tick();
    mb_cancel = 4'b0000;
    n_cmp++;
    if ({mb_abort, mb_busy, eng_if.tx_cancel} !== 9'b1000_0100_0) begin
      n_err++; $display("FAIL cancel_other: abort=%b busy=%b txc=%b want 1000/0100/0", mb_abort, mb_busy, eng_if.tx_cancel);
    end
    pulse_resp(0);
    n_cmp++;
    if (mb_done !== 4'b0100) begin n_err++; $display("FAIL cancel_other_done: got %b want 0100", mb_done); end
  endtask

  task automatic test_wr_reject();
    write_mb(0, 32'h111);
    mb_wr_en   = 1'b1;
    mb_wr_idx  = 2'd0;
    mb_wr_id   = 32'h022;
    mb_wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mb_wr_en   = 1'b0;
    n_cmp++;
    if (mb_wr_rej !== 1'b1) begin n_err++; $display("FAIL rej_pulse: got %b want 1", mb_wr_rej); end
    tick();
    n_cmp++;
    if (mb_wr_rej !== 1'b0) begin n_err++; $display("FAIL rej_one_cycle: got %b want 0", mb_wr_rej); end
    exp_q.push_back({32'h111, mkdata(0, 32'h111)});
    wait_req(64, seen, got, w);
    exp_f = exp_q.pop_front();
    n_cmp++;
    if (!seen || got !== exp_f) begin n_err++; $display("FAIL rej_unchanged: got %h want %h", got, exp_f); end
    tick(); pulse_resp(0);
    n_cmp++;
    if (mb_done !== 4'b0001) begin n_err++; $display("FAIL rej_done: got %b want 0001", mb_done); end
  endtask

  task automatic test_watchdog();
    int n;
    write_mb(2, 32'h333);
    exp_q.push_back({32'h333, mkdata(2, 32'h333)});
    wait_req(64, seen, got, w);
    exp_f = exp_q.pop_front();
    n_cmp++;
    if (!seen || got !== exp_f) begin n_err++; $display("FAIL wdog_req: got %h want %h", got, exp_f); end
    n = 0;
    while (n < 64) begin
      tick();
      n++;
      if (mb_abort != 4'b0) break;
    end
    n_cmp++;
    if ({mb_abort, eng_if.tx_cancel, mb_busy} !== 9'b0100_1_0000) begin
      n_err++; $display("FAIL wdog_abort: abort=%b txc=%b busy=%b want 0100/1/0000", mb_abort, eng_if.tx_cancel, mb_busy);
    end
    n_cmp++;
    if (n < int'(WDOG_CYCLES) || n > int'(WDOG_CYCLES) + 2) begin
      n_err++; $display("FAIL wdog_delay: got %0d cycles want %0d..%0d", n, WDOG_CYCLES, WDOG_CYCLES + 2);
    end
    tick();
    n_cmp++;
    if (eng_if.tx_cancel !== 1'b0) begin n_err++; $display("FAIL wdog_cancel_pulse: got %b want 0", eng_if.tx_cancel); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] acc_done, acc_abort;
    bit         acc_req;
    write_mb(0, 32'h5);
    write_mb(1, 32'h6);
    exp_q.push_back({32'h5, mkdata(0, 32'h5)});
    wait_req(64, seen, got, w);
    exp_f = exp_q.pop_front();
    n_cmp++;
    if (!seen || got !== exp_f) begin n_err++; $display("FAIL rstmid_req: got %h want %h", got, exp_f); end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({mb_busy, mb_done, mb_abort, mb_wr_rej, eng_if.tx_req, eng_if.tx_cancel} !== 15'b0 ||
        {eng_if.tx_id, eng_if.tx_data} !== 96'b0) begin
      n_err++; $display("FAIL rstmid_outputs: busy=%b done=%b abort=%b req=%b txc=%b id=%h", mb_busy, mb_done,
                        mb_abort, eng_if.tx_req, eng_if.tx_cancel, eng_if.tx_id);
    end
    rst = 1'b0;
    acc_done = '0; acc_abort = '0; acc_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc_done  |= mb_done;
      acc_abort |= mb_abort;
      acc_req   |= eng_if.tx_req;
    end
    n_cmp++;
    if ({acc_done, acc_abort, acc_req} !== 9'b0) begin
      n_err++; $display("FAIL rstmid_quiet: done=%b abort=%b req=%b want none", acc_done, acc_abort, acc_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    mb_wr_en          = 1'b0;
    mb_wr_idx         = '0;
    mb_wr_id          = '0;
    mb_wr_data        = '0;
    mb_cancel         = '0;
    eng_if.tx_done    = 1'b0;
    eng_if.arb_lost   = 1'b0;
    eng_if.active_err = 1'b0;
    eng_if.tx_empty   = 1'b1;

    test_reset();
    test_priority();
    test_tie();
    test_arb_lost();
    test_retry();
    test_cancel();
    test_wr_reject();
    test_watchdog();
    test_reset_mid();

    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_mbox_sched.md
Name: can_tx_mbox_sched

Overview:
Transmit-mailbox scheduler that sits between the CAN register/APB front end and the CAN TX bit engine (tx_id/tx_data/tx_req/tx_done/arb_lost/active_err interface). It holds NUM_MBOX pending frames and always offers the highest-priority one (lowest ID) to the engine. It re-queues the frame after lost arbitration, retries after errors up to a limit, and handles per-mailbox cancel. It reports per-mailbox completion and abort status.

Parameters:
NUM_MBOX, 4, number of TX mailboxes (2..16)
ID_WIDTH, 32, identifier width passed to the TX engine
DATA_WIDTH, 64, payload width
RETRY_LIMIT, 8, active_err count after which a mailbox is aborted (1..255)
WDOG_CYCLES, 4096, max clk_can cycles in WAIT with no engine response

Ports:
clk_can  in  1  CAN core clock
rst  in  1  synchronous, active-high reset
mb_wr_en  in  1  load mailbox mb_wr_idx
mb_wr_idx  in  $clog2(NUM_MBOX)  target mailbox
mb_wr_id  in  ID_WIDTH  frame ID (bits [3:0] carry DLC per engine convention)
mb_wr_data  in  DATA_WIDTH  frame payload
mb_cancel  in  NUM_MBOX  per-mailbox cancel request, one-cycle pulse per bit
mb_busy  out  NUM_MBOX  mailbox holds a pending frame
mb_done  out  NUM_MBOX  one-cycle pulse: frame sent
mb_abort  out  NUM_MBOX  one-cycle pulse: frame cancelled, retry-exhausted or watchdog
mb_wr_rej  out  1  one-cycle pulse: write to a busy mailbox was dropped
tx_id  out  ID_WIDTH  to engine
tx_data  out  DATA_WIDTH  to engine
tx_req  out  1  to engine, one-cycle pulse
tx_cancel  out  1  to engine, level
tx_done  in  1  engine: frame complete
arb_lost  in  1  engine: arbitration lost
active_err  in  1  engine: error frame
tx_empty  in  1  engine idle

Behaviour:
- Reset: all mb_busy, retry counters, cancel flags, outputs = 0; state IDLE. Reset mid-frame drops every pending frame and emits no done/abort pulses.
- Write: mb_wr_en to a non-busy mailbox stores ID/data and sets busy at the next edge. A write to a busy mailbox is dropped; mb_wr_rej pulses the next cycle.
- Priority: winner is the busy mailbox with the numerically lowest tx_id[ID_WIDTH-1:0]. Ties go to the lowest index. Evaluated only in SELECT.
- FSM IDLE: if any mb_busy && tx_empty -> SELECT.
- FSM SELECT: latch winner index, tx_id and tx_data into output registers -> REQ.
- FSM REQ: tx_req=1 for exactly one cycle; clear watchdog -> WAIT.
- FSM WAIT, tx_done: clear busy[act]; mb_done[act] pulse; clear retry[act] -> IDLE.
- FSM WAIT, arb_lost: frame stays busy, retry count unchanged -> IDLE. The next SELECT re-arbitrates, so a newly written higher-priority mailbox can overtake.
- FSM WAIT, active_err: retry[act]++. If the new value equals RETRY_LIMIT: clear busy, mb_abort[act] pulse. Either way -> IDLE.
- FSM WAIT, watchdog reaches WDOG_CYCLES: tx_cancel=1 for one cycle; clear busy; mb_abort[act] pulse -> IDLE.
- Latency: write in cycle 0 to an idle system gives tx_req high in cycle 3.
- Cancel, non-active busy mailbox: clear busy; mb_abort pulse next cycle.
- Cancel, active mailbox (SELECT/REQ/WAIT): set cancel flag; hold tx_cancel=1 until the frame resolves.
  - tx_done -> mb_done (frame already went out).
  - arb_lost or active_err -> clear busy, mb_abort, no retry.
  - Cancel in SELECT suppresses tx_req: busy cleared, mb_abort, -> IDLE.
- Cancel on a non-busy mailbox is ignored.
- Simultaneous events:
  - Write and cancel to the same idle mailbox: write wins, cancel ignored.
  - tx_done with arb_lost or active_err in the same cycle: tx_done wins.
  - Multiple response pulses are never double-counted.
- Retry counters are 8 bits, saturating, cleared on write and on done.

Decomposition:
- can_pkg: state enum (IDLE, SELECT, REQ, WAIT), MBOX index width function, retry counter width.
- Sub-module can_prio_select: combinational lowest-ID/lowest-index finder over NUM_MBOX entries. Outputs win_idx and win_valid.

Test Plan:
- Write mb2 ID=0x120, mb0 ID=0x300 in the same idle period -> tx_req with tx_id=0x120 first; tx_done -> mb_done[2]; then tx_id=0x300, mb_done[0].
- mb1 ID=0x200 in WAIT; write mb3 ID=0x050; pulse arb_lost -> next tx_req carries 0x050; mb1 remains busy.
- RETRY_LIMIT=3: mb0 gets active_err ×3 -> tx_req issued 3 times, then mb_abort[0], mb_busy[0]=0.
- mb_cancel[1] while mb1 in WAIT -> tx_cancel high; arb_lost -> mb_abort[1] and no re-request. Repeat with tx_done instead -> mb_done[1].
- Write to busy mb0 -> mb_wr_rej pulse; stored ID is unchanged at the next tx_req.
- Engine silent for WDOG_CYCLES=16 -> tx_cancel pulse, mb_abort. Assert rst mid-WAIT -> all outputs 0 the next cycle, no pulses.
